// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg : shared types and sizes for the right barrel shift pipeline
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package shift_pkg;

  localparam int SHIFT_WIDTH  = 32;
  localparam int SHIFT_STAGES = 5;

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_ROR  = 2'b10,
    OP_RSVD = 2'b11
  } shift_op_t;

  typedef struct packed {
    logic [SHIFT_WIDTH-1:0]  data;
    logic [SHIFT_STAGES-1:0] shamt;
    shift_op_t               op;
  } stage_payload_t;

endpackage

`default_nettype wire

// File: rtl/right_shift_stage.sv
// ----------------------------------------------------------------------------
// right_shift_stage : one conditional right shift by a fixed distance DIST
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module right_shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  shift_op_t        op,
  output logic [WIDTH-1:0] result
);

  logic [DIST-1:0] w_fill;

  always_comb begin
    w_fill = '0;
    case (op)
      OP_SRA:  w_fill = {DIST{data[WIDTH-1]}};
      OP_ROR:  w_fill = data[DIST-1:0];
      default: w_fill = '0;
    endcase
    result = enable ? {w_fill, data[WIDTH-1:DIST]} : data;
  end

endmodule

`default_nettype wire

// File: rtl/right_barrel_shift_pipe.sv
// ----------------------------------------------------------------------------
// right_barrel_shift_pipe : 5-stage SRL/SRA/ROR shifter, valid/ready both sides
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module right_barrel_shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = SHIFT_WIDTH,
  parameter int STAGES = SHIFT_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STAGES-1:0] in_shamt,
  input  logic [1:0]        in_op,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
);

  logic [STAGES-1:0] r_valid;
  stage_payload_t    r_stage       [STAGES];

  logic [WIDTH-1:0]  w_stage_in    [STAGES];
  logic [STAGES-1:0] w_stage_shamt [STAGES];
  shift_op_t         w_stage_op    [STAGES];
  logic [WIDTH-1:0]  w_shifted     [STAGES];
  logic [STAGES-1:0] w_valid_in;
  logic [STAGES-1:0] w_load;

  // Shift-amount bits already consumed, and the last stage's op, are carried but never read.
  logic [STAGES-1:0] unused_shamt;
  logic              unused_op;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_stage_in[k]    = in_data;
        assign w_stage_shamt[k] = in_shamt;
        assign w_stage_op[k]    = shift_op_t'(in_op);
        assign w_valid_in[k]    = in_valid;
      end else begin : g_body
        assign w_stage_in[k]    = r_stage[k-1].data;
        assign w_stage_shamt[k] = r_stage[k-1].shamt;
        assign w_stage_op[k]    = r_stage[k-1].op;
        assign w_valid_in[k]    = r_valid[k-1];
      end

      // A stage can load unless it and every stage below it are full and the output is stalled.
      assign w_load[k]       = ~(&r_valid[STAGES-1:k]) | out_ready;
      assign unused_shamt[k] = ^r_stage[k].shamt;

      right_shift_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << k)
      ) u_shift (
        .data   (w_stage_in[k]),
        .enable (w_stage_shamt[k][k]),
        .op     (w_stage_op[k]),
        .result (w_shifted[k])
      );
    end
  endgenerate

  assign unused_op = ^r_stage[STAGES-1].op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_load[k]) begin
          r_valid[k] <= w_valid_in[k];
          r_stage[k] <= '{data: w_shifted[k], shamt: w_stage_shamt[k], op: w_stage_op[k]};
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_stage[STAGES-1].data;

endmodule

`default_nettype wire

// File: tb/tb_right_barrel_shift_pipe.sv
// ----------------------------------------------------------------------------
// tb_right_barrel_shift_pipe : scoreboard bench for right_barrel_shift_pipe
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_right_barrel_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;

  int total = 0;
  int bad   = 0;
  int in_cnt  = 0;
  int out_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  right_barrel_shift_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b01:   r = 32'($signed(d) >>> s);
      2'b10:   r = (d >> s) | (d << (6'd32 - {1'b0, s}));
      default: r = d >> s;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: record accepted inputs, compare emitted outputs, check stalled data.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_cnt++;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_data", out_data, exp_q.pop_front());
      end else if (out_valid && exp_q.size() != 0) begin
        check("stall_data", out_data, exp_q[0]);
      end
      if (in_valid && in_ready && !flush) begin
        exp_q.push_back(model(in_data, in_shamt, in_op));
        in_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_lat(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                          input logic [31:0] want);
    int cnt;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      tick();
      cnt++;
    end
    check("latency", 32'(cnt), 32'd4);
    check("dir_data", out_data, want);
    tick();
  endtask

  task automatic send3();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = $urandom | 32'h1; in_shamt = 5'(i); in_op = 2'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] bp_d [8];
  logic [4:0]  bp_s [8];
  logic [1:0]  bp_o [8];

  initial begin
    int acc;
    int c0;

    // Reset state
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Directed values and latency
    send_lat(32'h80000000, 5'd4,  2'b01, 32'hF8000000);
    send_lat(32'h80000000, 5'd4,  2'b00, 32'h08000000);
    send_lat(32'h12345678, 5'd8,  2'b10, 32'h78123456);
    send_lat(32'hFFFFFFFF, 5'd31, 2'b00, 32'h00000001);
    send_lat(32'hFFFFFFFF, 5'd31, 2'b01, 32'hFFFFFFFF);
    for (int op = 0; op < 4; op++) send_lat(32'hA5A5A5A5, 5'd0, 2'(op), 32'hA5A5A5A5);
    send_lat(32'h80000000, 5'd1,  2'b11, 32'h40000000);
    send_lat(32'h00000001, 5'd1,  2'b10, 32'h80000000);

    // Backpressure: fill with output stalled
    for (int i = 0; i < 8; i++) begin
      bp_d[i] = $urandom; bp_s[i] = 5'($urandom); bp_o[i] = 2'(i);
    end
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20 && acc < 8; c++) begin
      in_valid = 1'b1; in_data = bp_d[acc]; in_shamt = bp_s[acc]; in_op = bp_o[acc];
      @(negedge clk);
      if (!in_ready) break;
      acc++;
      tick();
    end
    check("bp_accepts", 32'(acc), 32'd5);
    repeat (3) tick();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    c0 = out_cnt;
    for (int c = 0; c < 8; c++) begin
      in_valid = (acc < 8);
      if (acc < 8) begin
        in_data = bp_d[acc]; in_shamt = bp_s[acc]; in_op = bp_o[acc];
      end
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 32'(acc), 32'd8);
    check("bp_stream", 32'(out_cnt - c0), 32'd8);
    repeat (6) tick();

    // Flush with three items in flight
    out_ready = 1'b0;
    send3();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    c0 = out_cnt;
    repeat (10) tick();
    check("flush_no_out", 32'(out_cnt - c0), 32'd0);

    // Asynchronous reset mid-cycle with items in flight
    out_ready = 1'b0;
    send3();
    repeat (4) tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", out_data, 32'h0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    c0 = out_cnt;
    repeat (10) tick();
    check("arst_no_out", 32'(out_cnt - c0), 32'd0);

    // Random traffic with random valid/ready
    c0 = in_cnt;
    for (int c = 0; c < 60000 && (in_cnt - c0) < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_shamt  = 5'($urandom);
      in_op     = 2'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    check("rand_count", 32'(in_cnt - c0), 32'd10000);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
